// File: rtl/ddr_capture_writer.sv
// ddr_capture_writer
// Drains 64-bit words from the pre-DDR FIFO (read latency 1) into a local
// burst buffer and writes them to the DDR controller user port as
// fixed-length bursts at incrementing addresses that wrap at ADDR_LIMIT.
// capture_done flushes a zero-padded partial burst and pulses done_out.
// Optional statistics (stall_cycles, max_fill_wait) exist only when
// DDR_WRITER_STATS_EN is defined.
//
// Handshake: a command transfers on a cycle with ddr_cmd_valid & ddr_cmd_ready,
// a data beat on a cycle with ddr_wvalid & ddr_wready. Once valid is raised it
// and its payload (address, data, wlast) stay stable until that transfer cycle.
// fifo_rd is a single-cycle read strobe; its word appears on fifo_dout one
// cycle later.
module ddr_capture_writer #(
    parameter int                ADDR_W     = 30,
    parameter int                BURST_LEN  = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [63:0]       ADDR_LIMIT = 64'h0000_0000_4000_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enabled,
    input  logic              capture_start,
    input  logic              capture_done,
    input  logic [63:0]       fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    output logic              ddr_cmd_valid,
    input  logic              ddr_cmd_ready,
    output logic [ADDR_W-1:0] ddr_cmd_addr,
    output logic [63:0]       ddr_wdata,
    output logic              ddr_wvalid,
    input  logic              ddr_wready,
    output logic              ddr_wlast,
    output logic              busy,
    output logic              wrapped,
    output logic [31:0]       words_written,
    output logic              done_out,
    output logic [2:0]        fsm_state
`ifdef DDR_WRITER_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       max_fill_wait
`endif
);

    localparam int               IDX_W       = $clog2(BURST_LEN);
    localparam int               CNT_W       = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(BURST_LEN);
    localparam logic [IDX_W-1:0] LAST_BEAT   = IDX_W'(BURST_LEN - 1);
    localparam logic [63:0]      BURST_BYTES = 64'(BURST_LEN * 8);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        CMD    = 3'd2,
        DATA   = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [63:0]       burst_buf [BURST_LEN];
    logic [CNT_W-1:0]  rd_issued;
    logic [CNT_W-1:0]  cap_count;
    logic [CNT_W-1:0]  cap_next;
    logic [CNT_W-1:0]  real_count;
    logic [IDX_W-1:0]  beat;
    logic              rd_inflight;
    logic              done_pending;
    logic              start_pending;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       addr_sum;

    logic              arm;
    logic              seal;
    logic              cmd_fire;
    logic              beat_fire;
    logic              last_fire;
    logic              drain_idle;
    logic              padded;

    assign cmd_fire   = ddr_cmd_valid & ddr_cmd_ready;
    assign beat_fire  = ddr_wvalid & ddr_wready;
    assign last_fire  = beat_fire & (beat == LAST_BEAT);
    assign cap_next   = cap_count + {{(CNT_W-1){1'b0}}, rd_inflight};
    assign drain_idle = done_pending & fifo_empty & ~rd_inflight;
    assign padded     = (real_count != FULL_CNT);
    assign addr_sum   = {{(64-ADDR_W){1'b0}}, addr} + BURST_BYTES;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshake strobes and the arm (new capture) / seal (burst
    // buffer closed) controls. A start in CMD/DATA only latches and is acted
    // on after wlast so the controller never sees a truncated burst.
    always_comb begin
        state_next    = state;
        fifo_rd       = 1'b0;
        ddr_cmd_valid = 1'b0;
        ddr_wvalid    = 1'b0;
        arm           = 1'b0;
        seal          = 1'b0;
        case (state)
            IDLE: begin
                if (capture_start) begin
                    state_next = FILL;
                    arm        = 1'b1;
                end
            end
            FILL: begin
                if (capture_start) begin
                    arm = 1'b1;
                end else begin
                    fifo_rd = ~fifo_empty & (rd_issued < FULL_CNT) & enabled;
                    if (cap_next == FULL_CNT) begin
                        state_next = CMD;
                        seal       = 1'b1;
                    end else if (drain_idle && (cap_count != '0)) begin
                        state_next = CMD;
                        seal       = 1'b1;
                    end else if (drain_idle) begin
                        state_next = FINISH;
                    end
                end
            end
            CMD: begin
                ddr_cmd_valid = 1'b1;
                if (ddr_cmd_ready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                ddr_wvalid = 1'b1;
                if (last_fire) begin
                    if (start_pending || capture_start) begin
                        state_next = FILL;
                        arm        = 1'b1;
                    end else if (padded || (done_pending && fifo_empty)) begin
                        state_next = FINISH;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!enabled) begin
            state_next = IDLE;
            arm        = 1'b0;
            seal       = 1'b0;
        end
    end

    // Burst buffer fill, beat counter, address, and capture bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BURST_LEN; i++) begin
                burst_buf[i] <= '0;
            end
            rd_issued     <= '0;
            cap_count     <= '0;
            real_count    <= '0;
            beat          <= '0;
            rd_inflight   <= 1'b0;
            done_pending  <= 1'b0;
            start_pending <= 1'b0;
            addr          <= START_ADDR;
            wrapped       <= 1'b0;
            words_written <= '0;
        end else begin
            rd_inflight <= fifo_rd;

            if (arm || seal || !enabled) begin
                rd_issued <= '0;
                cap_count <= '0;
            end else if (state == FILL) begin
                if (fifo_rd) begin
                    rd_issued <= rd_issued + CNT_W'(1);
                end
                if (rd_inflight) begin
                    cap_count <= cap_next;
                end
            end

            // A word returning while a restart is taken is simply not stored.
            if ((state == FILL) && rd_inflight && !capture_start && enabled) begin
                burst_buf[cap_count[IDX_W-1:0]] <= fifo_dout;
            end

            if (seal) begin
                real_count <= cap_next;
                beat       <= '0;
            end else if (beat_fire) begin
                beat <= beat + IDX_W'(1);
            end

            if (arm || !enabled) begin
                done_pending <= 1'b0;
            end else if (state == FINISH) begin
                done_pending <= 1'b0;
            end else if ((state != IDLE) && capture_done && !capture_start) begin
                done_pending <= 1'b1;
            end

            if (arm || !enabled) begin
                start_pending <= 1'b0;
            end else if (((state == CMD) || (state == DATA)) && capture_start) begin
                start_pending <= 1'b1;
            end

            if (arm) begin
                words_written <= '0;
            end else if (beat_fire && ({1'b0, beat} < real_count) && (words_written != '1)) begin
                words_written <= words_written + 32'd1;
            end

            if (arm) begin
                addr    <= START_ADDR;
                wrapped <= 1'b0;
            end else if (last_fire) begin
                if (addr_sum >= ADDR_LIMIT) begin
                    addr    <= START_ADDR;
                    wrapped <= 1'b1;
                end else begin
                    addr <= addr_sum[ADDR_W-1:0];
                end
            end
        end
    end

`ifdef DDR_WRITER_STATS_EN
    logic [15:0] fill_wait_cur;
    logic [15:0] fill_wait_inc;

    assign fill_wait_inc = (fill_wait_cur == 16'hFFFF) ? fill_wait_cur : fill_wait_cur + 16'd1;

    // Saturating stall and FIFO-starvation statistics, cleared by capture_start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles  <= '0;
            max_fill_wait <= '0;
            fill_wait_cur <= '0;
        end else if (capture_start) begin
            stall_cycles  <= '0;
            max_fill_wait <= '0;
            fill_wait_cur <= '0;
        end else begin
            if (((ddr_wvalid && !ddr_wready) || (ddr_cmd_valid && !ddr_cmd_ready)) &&
                (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if ((state == FILL) && fifo_empty) begin
                fill_wait_cur <= fill_wait_inc;
                if (fill_wait_inc > max_fill_wait) begin
                    max_fill_wait <= fill_wait_inc;
                end
            end else begin
                fill_wait_cur <= '0;
            end
        end
    end
`endif

    assign ddr_cmd_addr = addr;
    assign ddr_wdata    = ((state == DATA) && ({1'b0, beat} < real_count)) ?
                          burst_buf[beat] : 64'h0;
    assign ddr_wlast    = (state == DATA) && (beat == LAST_BEAT);
    assign busy         = (state != IDLE);
    assign done_out     = (state == FINISH);
    assign fsm_state    = state;

endmodule

// File: tb/tb_ddr_capture_writer.sv
// Bench for ddr_capture_writer: a latency-1 FIFO model feeds two instances
// that share every input, one with the default address limit and one that
// wraps at 0x80. A negedge monitor checks every command address and data beat
// against expected queues filled by the directed tests.
module tb_ddr_capture_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enabled;
    logic        capture_start;
    logic        capture_done;
    logic [63:0] fifo_dout = '0;
    logic        fifo_empty;
    logic        fifo_rd;
    logic        ddr_cmd_valid;
    logic        ddr_cmd_ready = 1'b1;
    logic [29:0] ddr_cmd_addr;
    logic [63:0] ddr_wdata;
    logic        ddr_wvalid;
    logic        ddr_wready = 1'b1;
    logic        ddr_wlast;
    logic        busy;
    logic        wrapped;
    logic [31:0] words_written;
    logic        done_out;
    logic [2:0]  fsm_state;

    logic        b_fifo_rd;
    logic        b_cmd_valid;
    logic [29:0] b_cmd_addr;
    logic [63:0] b_wdata;
    logic        b_wvalid;
    logic        b_wlast;
    logic        b_busy;
    logic        b_wrapped;
    logic [31:0] b_words_written;
    logic        b_done_out;
    logic [2:0]  b_fsm_state;
`ifdef DDR_WRITER_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] max_fill_wait;
    logic [31:0] b_stall_cycles;
    logic [15:0] b_max_fill_wait;
    int          stall_exp = 0;
`endif

    // Scoreboard state.
    logic [63:0] exp_addr_q[$];
    logic [63:0] exp_addr_b_q[$];
    logic [63:0] exp_data_q[$];
    logic [63:0] exp_last_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cmd_cnt  = 0;
    int          beat_cnt = 0;
    int          done_cnt = 0;

    // Ready pattern controls.
    logic        bp_mode  = 1'b0;
    int          cmd_wait = 0;

    // FIFO model.
    logic [63:0] fifo_mem [256];
    logic [7:0]  wr_ptr = '0;
    logic [7:0]  rd_ptr = '0;

    ddr_capture_writer #(
        .ADDR_W(30), .BURST_LEN(8), .START_ADDR(30'h0), .ADDR_LIMIT(64'h4000_0000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enabled(enabled),
        .capture_start(capture_start), .capture_done(capture_done),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .ddr_cmd_valid(ddr_cmd_valid), .ddr_cmd_ready(ddr_cmd_ready),
        .ddr_cmd_addr(ddr_cmd_addr), .ddr_wdata(ddr_wdata),
        .ddr_wvalid(ddr_wvalid), .ddr_wready(ddr_wready), .ddr_wlast(ddr_wlast),
        .busy(busy), .wrapped(wrapped), .words_written(words_written),
        .done_out(done_out), .fsm_state(fsm_state)
`ifdef DDR_WRITER_STATS_EN
        , .stall_cycles(stall_cycles), .max_fill_wait(max_fill_wait)
`endif
    );

    ddr_capture_writer #(
        .ADDR_W(30), .BURST_LEN(8), .START_ADDR(30'h0), .ADDR_LIMIT(64'h80)
    ) dut_wrap (
        .clk(clk), .reset_n(reset_n), .enabled(enabled),
        .capture_start(capture_start), .capture_done(capture_done),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd(b_fifo_rd),
        .ddr_cmd_valid(b_cmd_valid), .ddr_cmd_ready(ddr_cmd_ready),
        .ddr_cmd_addr(b_cmd_addr), .ddr_wdata(b_wdata),
        .ddr_wvalid(b_wvalid), .ddr_wready(ddr_wready), .ddr_wlast(b_wlast),
        .busy(b_busy), .wrapped(b_wrapped), .words_written(b_words_written),
        .done_out(b_done_out), .fsm_state(b_fsm_state)
`ifdef DDR_WRITER_STATS_EN
        , .stall_cycles(b_stall_cycles), .max_fill_wait(b_max_fill_wait)
`endif
    );

    // Clock.
    always #5 clk = ~clk;

    // Standard-mode FIFO: data appears the cycle after the read strobe.
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_rd && !fifo_empty) begin
            fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    // Controller ready: always high, or cmd_ready low for 5 valid cycles and
    // wready toggling every cycle.
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            if (ddr_cmd_valid) cmd_wait = cmd_wait + 1;
            else cmd_wait = 0;
            ddr_cmd_ready = (cmd_wait > 5);
            ddr_wready    = ~ddr_wready;
        end else begin
            cmd_wait      = 0;
            ddr_cmd_ready = 1'b1;
            ddr_wready    = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Monitor: sampled mid-cycle, when the ready/valid of the coming edge are stable.
    always @(negedge clk) begin
        if (reset_n) begin
            if (ddr_cmd_valid) begin
                check("cmd_expected", 64'(exp_addr_q.size() > 0), 64'd1);
                if (exp_addr_q.size() > 0) begin
                    check("cmd_addr", 64'(ddr_cmd_addr), exp_addr_q[0]);
                    if (ddr_cmd_ready) void'(exp_addr_q.pop_front());
                end
                if (ddr_cmd_ready) cmd_cnt++;
            end
            if (b_cmd_valid) begin
                check("wrap_cmd_expected", 64'(exp_addr_b_q.size() > 0), 64'd1);
                if (exp_addr_b_q.size() > 0) begin
                    check("wrap_cmd_addr", 64'(b_cmd_addr), exp_addr_b_q[0]);
                    if (ddr_cmd_ready) void'(exp_addr_b_q.pop_front());
                end
            end
            if (ddr_wvalid && ddr_wready) begin
                check("beat_expected", 64'(exp_data_q.size() > 0), 64'd1);
                if (exp_data_q.size() > 0) begin
                    check("wdata", ddr_wdata, exp_data_q.pop_front());
                    check("wlast", 64'(ddr_wlast), exp_last_q.pop_front());
                end
                beat_cnt++;
            end
            if (done_out) done_cnt++;
`ifdef DDR_WRITER_STATS_EN
            if ((ddr_wvalid && !ddr_wready) || (ddr_cmd_valid && !ddr_cmd_ready)) stall_exp++;
`endif
        end
    end

    // Driver tasks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr] = base + 64'(i);
            wr_ptr = wr_ptr + 8'd1;
        end
    endtask

    // Expected beats: n real words then zero padding to a whole burst.
    task automatic expect_words(input int n, input logic [63:0] base);
        int total;
        total = ((n + 7) / 8) * 8;
        for (int i = 0; i < total; i++) begin
            exp_data_q.push_back((i < n) ? base + 64'(i) : 64'h0);
            exp_last_q.push_back(64'((i % 8) == 7));
        end
    endtask

    task automatic expect_cmd(input logic [63:0] a, input logic [63:0] b);
        exp_addr_q.push_back(a);
        exp_addr_b_q.push_back(b);
    endtask

    task automatic pulse_start();
        step();
        capture_start = 1'b1;
        step();
        capture_start = 1'b0;
`ifdef DDR_WRITER_STATS_EN
        stall_exp = 0;
`endif
    endtask

    task automatic pulse_done();
        step();
        capture_done = 1'b1;
        step();
        capture_done = 1'b0;
    endtask

    // Wait for done_out, then check it is a single pulse and the end state.
    task automatic finish_capture(input string tag, input logic [31:0] exp_ww);
        int n;
        int d0;
        n  = 0;
        d0 = done_cnt;
        while (!done_out && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_out), 64'd1);
        @(negedge clk);
        check({tag, "_done_single"}, 64'(done_out), 64'd0);
        @(negedge clk);
        check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check({tag, "_words"}, 64'(words_written), 64'(exp_ww));
        check({tag, "_wrap_words"}, 64'(b_words_written), 64'(exp_ww));
        check({tag, "_cmds_left"}, 64'(exp_addr_q.size()), 64'd0);
        check({tag, "_beats_left"}, 64'(exp_data_q.size()), 64'd0);
    endtask

    task automatic wait_cmd(input string tag, input int target);
        int n;
        n = 0;
        while (!(cmd_cnt == target && ddr_cmd_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(cmd_cnt == target && ddr_cmd_valid), 64'd1);
    endtask

    task automatic wait_beats(input string tag, input int target);
        int n;
        n = 0;
        while (beat_cnt < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(beat_cnt >= target), 64'd1);
    endtask

    // Stop a runaway run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end

    // Directed tests.
    initial begin
        int c0;
        int b0;
        reset_n       = 1'b0;
        enabled       = 1'b0;
        capture_start = 1'b0;
        capture_done  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cmd_valid", 64'(ddr_cmd_valid), 64'd0);
        check("rst_wvalid", 64'(ddr_wvalid), 64'd0);
        check("rst_fifo_rd", 64'(fifo_rd), 64'd0);
        check("rst_addr", 64'(ddr_cmd_addr), 64'h0);
        check("rst_words", 64'(words_written), 64'd0);
        check("rst_done", 64'(done_out), 64'd0);
        step();
        reset_n = 1'b1;
        enabled = 1'b1;
        step();

        // Three full bursts.
        push_words(24, 64'hA0A0_0000_0000_0000);
        expect_words(24, 64'hA0A0_0000_0000_0000);
        expect_cmd(64'h00, 64'h00);
        expect_cmd(64'h40, 64'h40);
        expect_cmd(64'h80, 64'h00);
        pulse_start();
        pulse_done();
        finish_capture("full", 32'd24);
        check("full_wrapped", 64'(wrapped), 64'd0);
        check("full_wrap_wrapped", 64'(b_wrapped), 64'd1);

        // Partial flush: 8 + 3 real words, 5 zero pads.
        push_words(11, 64'hB0B0_0000_0000_0100);
        expect_words(11, 64'hB0B0_0000_0000_0100);
        expect_cmd(64'h00, 64'h00);
        expect_cmd(64'h40, 64'h40);
        pulse_start();
        pulse_done();
        finish_capture("partial", 32'd11);

        // Backpressure on both command and data channels.
        bp_mode = 1'b1;
        push_words(16, 64'hC0C0_0000_0000_0200);
        expect_words(16, 64'hC0C0_0000_0000_0200);
        expect_cmd(64'h00, 64'h00);
        expect_cmd(64'h40, 64'h40);
        pulse_start();
        pulse_done();
        finish_capture("bp", 32'd16);
`ifdef DDR_WRITER_STATS_EN
        check("bp_stall_cycles", 64'(stall_cycles), 64'(stall_exp));
`endif
        bp_mode = 1'b0;
        step();

        // Wrap: the 0x80-limit instance returns to 0 on the third burst.
        c0 = cmd_cnt;
        push_words(20, 64'hD0D0_0000_0000_0300);
        expect_words(20, 64'hD0D0_0000_0000_0300);
        expect_cmd(64'h00, 64'h00);
        expect_cmd(64'h40, 64'h40);
        expect_cmd(64'h80, 64'h00);
        pulse_start();
        pulse_done();
        wait_cmd("wrap_cmd2_seen", c0 + 1);
        check("wrap_before_2nd", 64'(b_wrapped), 64'd0);
        wait_cmd("wrap_cmd3_seen", c0 + 2);
        check("wrap_after_2nd", 64'(b_wrapped), 64'd1);
        check("wrap_nowrap_inst", 64'(wrapped), 64'd0);
        finish_capture("wrap", 32'd20);

        // Restart during burst 1: burst completes, next burst at START_ADDR.
        c0 = cmd_cnt;
        b0 = beat_cnt;
        push_words(16, 64'hE0E0_0000_0000_0400);
        expect_words(16, 64'hE0E0_0000_0000_0400);
        expect_cmd(64'h00, 64'h00);
        expect_cmd(64'h00, 64'h00);
        pulse_start();
        wait_beats("restart_mid_data", b0 + 3);
        pulse_start();
        wait_cmd("restart_cmd2_seen", c0 + 1);
        pulse_done();
        finish_capture("restart", 32'd8);

        // Asynchronous reset in the middle of burst 2.
        c0 = cmd_cnt;
        b0 = beat_cnt;
        push_words(16, 64'hF0F0_0000_0000_0500);
        expect_words(16, 64'hF0F0_0000_0000_0500);
        expect_cmd(64'h00, 64'h00);
        expect_cmd(64'h40, 64'h40);
        pulse_start();
        wait_beats("reset_mid_data", b0 + 11);
        @(posedge clk);
        #2;
        check("pre_reset_addr", 64'(ddr_cmd_addr), 64'h40);
        reset_n = 1'b0;
        #1;
        check("areset_busy", 64'(busy), 64'd0);
        check("areset_wvalid", 64'(ddr_wvalid), 64'd0);
        check("areset_wlast", 64'(ddr_wlast), 64'd0);
        check("areset_wdata", ddr_wdata, 64'h0);
        check("areset_cmd_valid", 64'(ddr_cmd_valid), 64'd0);
        check("areset_fifo_rd", 64'(fifo_rd), 64'd0);
        check("areset_addr", 64'(ddr_cmd_addr), 64'h0);
        check("areset_wrap_addr", 64'(b_cmd_addr), 64'h0);
        check("areset_words", 64'(words_written), 64'd0);
        exp_addr_q.delete();
        exp_addr_b_q.delete();
        exp_data_q.delete();
        exp_last_q.delete();
        step();
        reset_n = 1'b1;
        step();
        @(negedge clk);
        check("post_reset_busy", 64'(busy), 64'd0);
        check("post_reset_wvalid", 64'(ddr_wvalid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
